// File: rtl/bsod_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bsod_mode_ctrl
// Description : Selects between HDMI pass-through and the BSOD picture.
//               A debounced active-low button (trig_n) or the force_bsod
//               level arms a switch.  The switch is applied on the next
//               frame start (vs_in rising edge).  A watchdog forces the
//               switch if vsync goes missing.  The optional hold timer
//               (macro BSOD_HOLD_TIMER_EN) leaves BSOD after HOLD_FRAMES
//               frames.  Without that macro, BSOD is left only by a press
//               while force_bsod is low.
//
// Ports       : clk_in      in   148.5 MHz pixel clock (only clock)
//               resetb      in   synchronous active-low reset
//               trig_n      in   asynchronous active-low button
//               force_bsod  in   level; 1 holds BSOD indefinitely
//               vs_in       in   active-high vsync, synchronous to clk_in
//               hdmi_sw     out  1 = pass-through, 0 = BSOD (registered)
//               bsod_active out  1 while in BSOD (registered)
//               state_o     out  current state encoding
//
// Config      : `define BSOD_HOLD_TIMER_EN enables the frame-count exit
//
// Revision    : 1.0  initial release
// ============================================================================
module bsod_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1485000,
  parameter int HOLD_FRAMES     = 600,
  parameter int VS_TIMEOUT      = 2970000
) (
  input  logic       clk_in,
  input  logic       resetb,
  input  logic       trig_n,
  input  logic       force_bsod,
  input  logic       vs_in,
  output logic       hdmi_sw,
  output logic       bsod_active,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_PASS   = 2'b00,
    ST_ARM    = 2'b01,
    ST_BSOD   = 2'b10,
    ST_DISARM = 2'b11
  } state_t;

  localparam int c_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int c_WD_W = (VS_TIMEOUT > 1) ? $clog2(VS_TIMEOUT) : 1;
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(VS_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_hdmi_sw;
  logic              r_bsod_active;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_db_level;
  logic [c_DB_W-1:0] r_db_cnt;
  logic              w_db_accept;
  logic              w_press;

  logic              r_vs;
  logic              r_vs_prev;
  logic              r_frame_start;

  logic [c_WD_W-1:0] r_wd_cnt;
  logic              w_wd_run;
  logic              w_wd_expired;

  logic              w_frame_last;

  // --------------------------------------------------------------------------
  // Button: 2-flop synchronizer followed by a debouncer.  The counter tracks
  // how many consecutive samples have disagreed with the accepted level; it
  // restarts whenever the input agrees again, so it never passes c_DB_LAST.
  // --------------------------------------------------------------------------
  assign w_db_accept = (r_sync2 != r_db_level) && (r_db_cnt == c_DB_LAST);
  // Only the accepted 1->0 transition is an event; release is silent.
  assign w_press     = w_db_accept && !r_sync2;

  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_db_level <= 1'b1;
      r_db_cnt   <= '0;
    end else begin
      r_sync1 <= trig_n;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (w_db_accept) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + c_DB_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame start: vs_in registered once, edge-detected, and the pulse itself
  // registered.  A rising edge captured at edge N therefore moves the state
  // (and hdmi_sw) at edge N+2.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      r_vs          <= 1'b0;
      r_vs_prev     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_vs          <= vs_in;
      r_vs_prev     <= r_vs;
      r_frame_start <= r_vs && !r_vs_prev;
    end
  end

  // --------------------------------------------------------------------------
  // Missing-vsync watchdog: runs only while a switch is pending.
  // --------------------------------------------------------------------------
  assign w_wd_run     = (r_state == ST_ARM) || (r_state == ST_DISARM);
  assign w_wd_expired = w_wd_run && (r_wd_cnt == c_WD_LAST);

  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      r_wd_cnt <= '0;
    end else if (!w_wd_run || r_frame_start || (w_state_next != r_state)) begin
      // Leaving a state clears it, so every entry starts from zero.
      r_wd_cnt <= '0;
    end else if (r_wd_cnt != c_WD_LAST) begin
      r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Optional hold timer: counts frames spent in BSOD.
  // --------------------------------------------------------------------------
`ifdef BSOD_HOLD_TIMER_EN
  localparam int c_FRM_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [c_FRM_W-1:0] c_FRM_LAST = c_FRM_W'(HOLD_FRAMES - 1);

  logic [c_FRM_W-1:0] r_frame_cnt;

  assign w_frame_last = (r_frame_cnt == c_FRM_LAST);

  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      r_frame_cnt <= '0;
    end else if ((r_state == ST_ARM) && (w_state_next == ST_BSOD)) begin
      r_frame_cnt <= '0;
    end else if ((r_state == ST_BSOD) && !force_bsod && r_frame_start &&
                 (w_state_next == ST_BSOD) && !w_frame_last) begin
      // Frozen while forced; the last frame exits instead of wrapping, and
      // a DISARM->BSOD re-entry keeps the count.
      r_frame_cnt <= r_frame_cnt + c_FRM_W'(1);
    end
  end
`else
  // No hold timer: BSOD never ends on a frame count.
  assign w_frame_last = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Mode FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_PASS: begin
        if (w_press || force_bsod) begin
          w_state_next = ST_ARM;
        end
      end
      ST_ARM: begin
        // A frame start in the same cycle as a press still switches.
        if (r_frame_start || w_wd_expired) begin
          w_state_next = ST_BSOD;
        end else if (w_press && !force_bsod) begin
          w_state_next = ST_PASS;
        end
      end
      ST_BSOD: begin
        if (!force_bsod) begin
          if (w_press) begin
            w_state_next = ST_DISARM;
          end else if (r_frame_start && w_frame_last) begin
            w_state_next = ST_DISARM;
          end
        end
      end
      ST_DISARM: begin
        if (force_bsod) begin
          w_state_next = ST_BSOD;
        end else if (r_frame_start || w_wd_expired) begin
          w_state_next = ST_PASS;
        end
      end
      default: begin
        w_state_next = ST_PASS;
      end
    endcase
  end

  // Outputs are registered from the next state so they move with state_o.
  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      r_state       <= ST_PASS;
      r_hdmi_sw     <= 1'b1;
      r_bsod_active <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_hdmi_sw     <= (w_state_next != ST_BSOD);
      r_bsod_active <= (w_state_next == ST_BSOD);
    end
  end

  assign hdmi_sw     = r_hdmi_sw;
  assign bsod_active = r_bsod_active;
  assign state_o     = r_state;

endmodule
`default_nettype wire
